// File: rtl/hack_defs.sv
// Shared Hack platform constants: memory-mapped addresses and keyboard codes.
package hack_defs;

  localparam logic [15:0] KBD_ADDR      = 16'h6000;
  localparam logic [15:0] SCREEN_ADDR   = 16'h4000;
  localparam logic [15:0] KEY_NONE      = 16'h0000;
  localparam logic [15:0] KEY_NEWLINE   = 16'd128;
  localparam logic [15:0] KEY_BACKSPACE = 16'd129;
  localparam logic [15:0] KEY_LEFT      = 16'd130;
  localparam logic [15:0] KEY_UP        = 16'd131;
  localparam logic [15:0] KEY_RIGHT     = 16'd132;
  localparam logic [15:0] KEY_DOWN      = 16'd133;
  localparam logic [15:0] KEY_ESC       = 16'd140;

  // A code of zero means "no key" and is never queued.
  function automatic logic is_key(input logic [15:0] code);
    return code != KEY_NONE;
  endfunction

endpackage

// File: rtl/fifo_core16.sv
// Generic 16-bit register-array FIFO; full/empty derive from the entry count.
module fifo_core16 #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage is not reset; a write in a reset cycle is suppressed anyway.
  always_ff @(posedge clock) begin
    if (do_push && !reset) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_fifo16.sv
// Hack KBD input buffer: filters zero codes, zero-gates the head word and
// tracks a sticky overflow flag for codes dropped while full.
module kbd_fifo16
  import hack_defs::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [15:0]   in_data,
  output logic          in_ready,
  input  logic          ack,
  input  logic          clr_ovf,
  output logic [15:0]   out,
  output logic [AW:0]   count,
  output logic          overflow
);

  logic [15:0] head;
  logic        full;
  logic        empty;
  logic        push_req;

  assign push_req = in_valid && is_key(in_data);
  assign in_ready = !full;
  assign out      = empty ? KEY_NONE : head;

  fifo_core16 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (ack),
    .wdata (in_data),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Drop-while-full sets the flag and beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_req && full) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kbd_fifo16.sv
// Scenario bench for kbd_fifo16 with a queue scoreboard of expected entries.
module tb_kbd_fifo16;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_data = 16'h0000;
  logic          in_ready;
  logic          ack = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [15:0]   out;
  logic [AW:0]   count;
  logic          overflow;

  int            checks = 0;
  int            errors = 0;
  logic [15:0]   exp_q[$];
  logic          exp_ovf = 1'b0;

  always #5 clock = ~clock;

  kbd_fifo16 #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ack      (ack),
    .clr_ovf  (clr_ovf),
    .out      (out),
    .count    (count),
    .overflow (overflow)
  );

  function automatic logic [15:0] model_out();
    return (exp_q.size() == 0) ? 16'h0000 : exp_q[0];
  endfunction

  // Drive one cycle of stimulus, update the scoreboard, settle 1ns past the edge.
  task automatic drive(input logic r, input logic v, input logic [15:0] d,
                       input logic a, input logic c);
    logic was_full;
    reset = r; in_valid = v; in_data = d; ack = a; clr_ovf = c;
    was_full = (exp_q.size() == DEPTH);
    if (r) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      if (v && d != 16'h0000 && was_full) exp_ovf = 1'b1;
      else if (c) exp_ovf = 1'b0;
      if (a && exp_q.size() != 0) void'(exp_q.pop_front());
      if (v && d != 16'h0000 && !was_full) exp_q.push_back(d);
    end
    @(posedge clock);
    #1;
    reset = 1'b0; in_valid = 1'b0; in_data = 16'h0000; ack = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (out !== 16'h0000) begin errors++; $display("FAIL reset_out got %h want 0000", out); end
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %0b want 1", in_ready); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
  endtask

  task automatic test_push_pop();
    drive(1'b0, 1'b1, 16'h0041, 1'b0, 1'b0);
    checks++;
    if (out !== 16'h0041) begin errors++; $display("FAIL first_push_out got %h want 0041", out); end
    drive(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd2 || out !== 16'h0041) begin
      errors++; $display("FAIL two_push got count %0d out %h want 2 0041", count, out);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if (out !== 16'h0042 || count !== 4'd1) begin
      errors++; $display("FAIL ack1 got out %h count %0d want 0042 1", out, count);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if (out !== 16'h0000 || count !== 4'd0) begin
      errors++; $display("FAIL ack2 got out %h count %0d want 0000 0", out, count);
    end
  endtask

  task automatic test_full_overflow();
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 16'h0061 + 16'(i), 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || count !== 4'd8) begin
      errors++; $display("FAIL full got in_ready %0b count %0d want 0 8", in_ready, count);
    end
    drive(1'b0, 1'b1, 16'h0069, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || out !== 16'h0061 || count !== 4'd8) begin
      errors++; $display("FAIL drop got ovf %0b out %h count %0d want 1 0061 8", overflow, out, count);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %0b want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      exp = exp_q[0];
      checks++;
      if (out !== exp || out !== 16'h0061 + 16'(i)) begin
        errors++; $display("FAIL drain_%0d got %h want %h", i, out, 16'h0061 + 16'(i));
      end
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    end
    checks++;
    if (out !== 16'h0000 || count !== 4'd0) begin
      errors++; $display("FAIL drained got out %h count %0d want 0000 0", out, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 16'h0071 + 16'(i), 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0070, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd7 || overflow !== 1'b1 || out !== 16'h0072) begin
      errors++; $display("FAIL full_push_ack got count %0d ovf %0b out %h want 7 1 0072", count, overflow, out);
    end
    drive(1'b0, 1'b1, 16'h0079, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h007a, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL set_beats_clr got %0b want 1", overflow); end
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    checks++;
    if (overflow !== exp_ovf || overflow !== 1'b0) begin
      errors++; $display("FAIL clr_after got %0b want 0", overflow);
    end
    while (exp_q.size() != 0) begin
      exp = exp_q[0];
      checks++;
      if (out !== exp) begin errors++; $display("FAIL full_order got %h want %h", out, exp); end
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b1, 16'h0031, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0032, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0033, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0034, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd3 || out !== 16'h0032) begin
      errors++; $display("FAIL half_push_ack got count %0d out %h want 3 0032", count, out);
    end
    for (int i = 0; i < 3; i++) begin
      exp = exp_q[0];
      checks++;
      if (out !== exp || out !== 16'h0032 + 16'(i)) begin
        errors++; $display("FAIL half_order_%0d got %h want %h", i, out, 16'h0032 + 16'(i));
      end
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    end
  endtask

  task automatic test_zero_and_empty();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd0 || overflow !== 1'b0 || out !== 16'h0000) begin
      errors++; $display("FAIL zero_code got count %0d ovf %0b out %h want 0 0 0000", count, overflow, out);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd0 || out !== 16'h0000 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ack_empty got count %0d out %h rdy %0b want 0 0000 1", count, out, in_ready);
    end
    // Push on empty plus ack: pushed code lands, nothing popped.
    drive(1'b0, 1'b1, 16'h0055, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd1 || out !== 16'h0055) begin
      errors++; $display("FAIL empty_push_ack got count %0d out %h want 1 0055", count, out);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 16'h0100 + 16'(i * 3), 1'b0, 1'b0);
      checks++;
      if (out !== model_out() || out !== 16'h0100 + 16'(i * 3)) begin
        errors++; $display("FAIL wrap_%0d got %h want %h", i, out, 16'h0100 + 16'(i * 3));
      end
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    end
    checks++;
    if (count !== 4'd0 || out !== 16'h0000) begin
      errors++; $display("FAIL wrap_end got count %0d out %h want 0 0000", count, out);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 16'h0090 + 16'(i), 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL pre_reset_ovf got %0b want 1", overflow); end
    drive(1'b1, 1'b1, 16'h0066, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd0 || out !== 16'h0000 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got count %0d out %h ovf %0b rdy %0b want 0 0000 0 1",
                         count, out, overflow, in_ready);
    end
    drive(1'b0, 1'b1, 16'h0080, 1'b0, 1'b0);
    checks++;
    if (out !== 16'h0080 || count !== 4'd1) begin
      errors++; $display("FAIL post_reset got out %h count %0d want 0080 1", out, count);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_push_pop();
    test_full_overflow();
    test_back_to_back();
    test_zero_and_empty();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
